// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter: one shift stage per clock (8, 4, 2, 1), fixed CNT_W-cycle latency,
// valid/ready on both sides, synchronous flush from pipeline squash.
module shift_sequencer #(
    parameter int unsigned CNT_W = 4,
    localparam int unsigned WIDTH = 2 ** CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             busy
);

    localparam int unsigned KW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    localparam logic [1:0] OpRol = 2'b00;
    localparam logic [1:0] OpSll = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpSrl = 2'b11;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [KW-1:0]    k_q, k_d;

    int unsigned      shamt;
    logic [WIDTH-1:0] stage_val;

    // Single shift stage; the amount is the power of two selected by the stage index.
    always_comb begin
        shamt     = 32'd1 << k_q;
        stage_val = out_q;
        unique case (op_q)
            OpRol: stage_val = (out_q << shamt) | (out_q >> (WIDTH - shamt));
            OpSll: stage_val = out_q << shamt;
            OpSra: stage_val = $signed(out_q) >>> shamt;
            OpSrl: stage_val = out_q >> shamt;
            default: stage_val = out_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        k_d     = k_q;
        if (flush) begin
            state_d = StIdle;
            k_d     = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        out_d   = In;
                        cnt_d   = Cnt;
                        op_d    = Op;
                        k_d     = KW'(CNT_W - 1);
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (cnt_q[k_q]) begin
                        out_d = stage_val;
                    end
                    if (k_q == '0) begin
                        state_d = StDone;
                    end else begin
                        k_d = k_q - KW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign Out       = out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected results queued at accept, compared at retirement.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] sb[$];

    shift_sequencer #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (din),
        .Cnt       (cnt),
        .Op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: apply the operation one bit position at a time, Cnt times.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] c,
                                          input logic [1:0] o);
        logic [15:0] v = a;
        for (int i = 0; i < int'(c); i++) begin
            case (o)
                2'b00:   v = {v[14:0], v[15]};
                2'b01:   v = {v[14:0], 1'b0};
                2'b10:   v = {v[15], v[15:1]};
                default: v = {1'b0, v[15:1]};
            endcase
        end
        return v;
    endfunction

    // Retirement happens at the next rising edge when valid & ready are seen here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", 16'(out_valid), 16'd0);
            end else begin
                check_eq("result", dout, sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                         input logic [15:0] exp, input bit wait_res);
        int n;
        in_valid = 1'b1;
        din = a;
        cnt = c;
        op = o;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_wait", 16'(in_ready), 16'd1);
        sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din = 16'($urandom);
        cnt = 4'($urandom);
        op = 2'($urandom);
        check_eq("busy_after_accept", 16'(busy), 16'd1);
        if (wait_res) begin
            n = 0;
            while (!out_valid && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check_eq("latency", 16'(n), 16'd4);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        logic [3:0]  c;
        logic [1:0]  o;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        din = 16'h0;
        cnt = 4'h0;
        op = 2'b00;
        out_ready = 1'b1;
        #1;
        check_eq("rst_out", dout, 16'h0000);
        check_eq("rst_out_valid", 16'(out_valid), 16'd0);
        check_eq("rst_in_ready", 16'(in_ready), 16'd1);
        check_eq("rst_busy", 16'(busy), 16'd0);
        #11 rst = 1'b0;
        cycles(1);

        // SRL and follow-up readiness
        issue(16'h8421, 4'd4, 2'b11, 16'h0842, 1'b1);
        cycles(1);
        check_eq("ready_after_retire", 16'(in_ready), 16'd1);
        check_eq("valid_after_retire", 16'(out_valid), 16'd0);

        // Limits and rotates
        issue(16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b1);
        cycles(1);
        issue(16'h0001, 4'd15, 2'b01, 16'h8000, 1'b1);
        cycles(1);
        issue(16'hFFFF, 4'd15, 2'b11, 16'h0001, 1'b1);
        cycles(1);
        issue(16'h1234, 4'd4, 2'b00, 16'h2341, 1'b1);
        cycles(1);
        issue(16'h1234, 4'd0, 2'b00, 16'h1234, 1'b1);
        cycles(1);
        issue(16'h8001, 4'd1, 2'b00, 16'h0003, 1'b1);
        cycles(1);
        issue(16'hC35A, 4'd7, 2'b10, 16'hFF86, 1'b1);
        cycles(1);

        // Backpressure with a competing request held
        out_ready = 1'b0;
        issue(16'h00F0, 4'd2, 2'b01, 16'h03C0, 1'b1);
        in_valid = 1'b1;
        din = 16'hABCD;
        cnt = 4'd8;
        op = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check_eq("bp_out", dout, 16'h03C0);
            check_eq("bp_out_valid", 16'(out_valid), 16'd1);
            check_eq("bp_in_ready", 16'(in_ready), 16'd0);
        end
        out_ready = 1'b1;
        issue(16'hABCD, 4'd8, 2'b00, 16'hCDAB, 1'b1);
        cycles(1);

        // Flush in the second SHIFT cycle
        issue(16'h00FF, 4'd8, 2'b01, 16'hFF00, 1'b0);
        cycles(1);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        void'(sb.pop_back());
        check_eq("flush_in_ready", 16'(in_ready), 16'd1);
        check_eq("flush_out_valid", 16'(out_valid), 16'd0);
        cycles(6);
        check_eq("flush_no_valid", 16'(out_valid), 16'd0);
        issue(16'h00FF, 4'd8, 2'b01, 16'hFF00, 1'b1);
        cycles(1);

        // Flush coincident with an accept drops the request
        in_valid = 1'b1;
        flush = 1'b1;
        cycles(1);
        in_valid = 1'b0;
        flush = 1'b0;
        check_eq("flush_accept_busy", 16'(busy), 16'd0);

        // Flush coincident with retirement: result not delivered
        out_ready = 1'b0;
        issue(16'h4321, 4'd3, 2'b11, 16'h0864, 1'b1);
        out_ready = 1'b1;
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        void'(sb.pop_back());
        check_eq("flush_done_valid", 16'(out_valid), 16'd0);
        check_eq("flush_done_ready", 16'(in_ready), 16'd1);

        // Asynchronous reset between edges mid-SHIFT
        issue(16'h7777, 4'd5, 2'b11, 16'h03BB, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_out", dout, 16'h0000);
        check_eq("arst_out_valid", 16'(out_valid), 16'd0);
        check_eq("arst_in_ready", 16'(in_ready), 16'd1);
        sb.delete();
        #10 rst = 1'b0;
        cycles(1);
        issue(16'h0F0F, 4'd4, 2'b10, 16'h00F0, 1'b1);
        cycles(1);

        // Random operations against the bit-serial model
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            c = 4'($urandom);
            o = 2'($urandom);
            issue(a, c, o, model(a, c, o), 1'b1);
            cycles(1);
        end

        cycles(3);
        check_eq("sb_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
